otter_dmem_responder: RTL and testbench

Data-memory responder for the pipelined OTTER core: the slave end of the memory-stage request signals (MEM_READ2, MEM_WRITE2, MEM_SIZE, MEM_SIGN). It accepts one load/store request at a time, applies configurable wait states, performs byte/half/word access with sign/zero extension, and returns read data with a done pulse. While the access is outstanding it asserts a stall to the pipeline.

---
 rtl/otter_dmem_responder.sv | 198 +++++++++++++++++++
 tb/tb_otter_dmem_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/otter_dmem_responder.sv
// rtl/otter_dmem_responder.sv - data-memory responder for the pipelined OTTER memory stage
//
// Accepts one load/store at a time, inserts WAIT_STATES cycles, performs a
// byte/half/word access with sign/zero extension and pulses MEM_VALID.
// Optional feature macro: OTTER_DMEM_MISALIGN_ERR_EN (adds MEM_ERR and makes
// misaligned accesses fail instead of being silently aligned).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   MEM_READ2/MEM_WRITE2  load/store request levels, held while MEM_BUSY
//   MEM_SIZE, MEM_SIGN    0 byte / 1 half / 2,3 word; 1 = zero-extend
//   MEM_ADDR, MEM_DIN     byte address, right-aligned store data
//   MEM_DOUT              registered load data
//   MEM_VALID             one-cycle done pulse
//   MEM_ERR               misalignment flag (macro builds only)
//   MEM_BUSY              stall request to the pipeline
module otter_dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_READ2,
    input  logic        MEM_WRITE2,
    input  logic [1:0]  MEM_SIZE,
    input  logic        MEM_SIGN,
    input  logic [31:0] MEM_ADDR,
    input  logic [31:0] MEM_DIN,
    output logic [31:0] MEM_DOUT,
    output logic        MEM_VALID,
`ifdef OTTER_DMEM_MISALIGN_ERR_EN
    output logic        MEM_ERR,
`endif
    output logic        MEM_BUSY
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q;
    logic [2:0]    cnt_q;
    logic [AW+1:0] addr_q;
    logic [1:0]    size_q;
    logic          sign_q;
    logic          write_q;
    logic [31:0]   din_q;
    logic [31:0]   dout_q;
    logic          valid_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          req;
    logic          in_idle;
    logic          access;
    logic [AW+1:0] acc_addr;
    logic [1:0]    acc_size;
    logic          acc_sign;
    logic          acc_write;
    logic [31:0]   acc_din;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rword;
    logic [15:0]   shifted;
    logic [31:0]   load_d;
    logic          we;
    logic          mis;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^MEM_ADDR[31:AW+2];

    assign req     = MEM_READ2 | MEM_WRITE2;
    assign in_idle = (state_q == IDLE);

    // With zero wait states the access happens on the accept edge, so the
    // datapath must see the live request rather than the latched copy.
    assign acc_addr  = in_idle ? MEM_ADDR[AW+1:0] : addr_q;
    assign acc_size  = in_idle ? MEM_SIZE         : size_q;
    assign acc_sign  = in_idle ? MEM_SIGN         : sign_q;
    assign acc_write = in_idle ? MEM_WRITE2       : write_q;
    assign acc_din   = in_idle ? MEM_DIN          : din_q;

    // Gated by rst_n so a request held through reset never writes the array.
    assign access = rst_n & ((in_idle & req & (WS == 3'd0)) |
                             ((state_q == WAIT) & (cnt_q == 3'd0)));

    assign idx = acc_addr[AW+1:2];

    always_comb begin
        lane  = 2'b00;
        be    = 4'b1111;
        wdata = acc_din;
        mis   = 1'b0;
        case (acc_size)
            2'd0: begin
                lane  = acc_addr[1:0];
                be    = 4'b0001 << acc_addr[1:0];
                wdata = {4{acc_din[7:0]}};
            end
            2'd1: begin
                lane  = {acc_addr[1], 1'b0};
                be    = 4'b0011 << {acc_addr[1], 1'b0};
                wdata = {2{acc_din[15:0]}};
                mis   = acc_addr[0];
            end
            default: begin
                mis   = (acc_addr[1:0] != 2'b00);
            end
        endcase
    end

    assign rword   = mem[idx];
    assign shifted = 16'(rword >> {lane, 3'b000});

    always_comb begin
        load_d = rword;
        case (acc_size)
            2'd0:    load_d = acc_sign ? {24'd0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_d = acc_sign ? {16'd0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            default: load_d = rword;
        endcase
    end

`ifdef OTTER_DMEM_MISALIGN_ERR_EN
    logic err_q;
    assign we      = access & acc_write & ~mis;
    assign MEM_ERR = err_q;
`else
    logic unused_mis;
    assign unused_mis = mis;
    assign we         = access & acc_write;
`endif

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            size_q  <= 2'd0;
            sign_q  <= 1'b0;
            write_q <= 1'b0;
            din_q   <= 32'd0;
            dout_q  <= 32'd0;
            valid_q <= 1'b0;
`ifdef OTTER_DMEM_MISALIGN_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            valid_q <= access;
`ifdef OTTER_DMEM_MISALIGN_ERR_EN
            err_q   <= access & mis;
            if (access & ~acc_write) dout_q <= mis ? 32'd0 : load_d;
`else
            if (access & ~acc_write) dout_q <= load_d;
`endif
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= MEM_ADDR[AW+1:0];
                        size_q  <= MEM_SIZE;
                        sign_q  <= MEM_SIGN;
                        write_q <= MEM_WRITE2;
                        din_q   <= MEM_DIN;
                        if (WS == 3'd0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WS - 3'd1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 3'd0) state_q <= RESP;
                    else               cnt_q   <= cnt_q - 3'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MEM_DOUT  = dout_q;
    assign MEM_VALID = valid_q;
    assign MEM_BUSY  = rst_n & ((in_idle & req) | (state_q == WAIT));

endmodule

// File: tb/tb_otter_dmem_responder.sv
// tb/tb_otter_dmem_responder.sv - randomized self-checking bench for otter_dmem_responder
module tb_otter_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // index 0: WAIT_STATES=1, 1024 words; index 1: WAIT_STATES=0, 16 words
    logic        rd   [2];
    logic        wr   [2];
    logic        sg   [2];
    logic [1:0]  sz   [2];
    logic [31:0] ad   [2];
    logic [31:0] di   [2];
    logic [31:0] dout [2];
    logic        valid[2];
    logic        busy [2];
`ifdef OTTER_DMEM_MISALIGN_ERR_EN
    logic        err  [2];
`endif

    otter_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .MEM_READ2(rd[0]), .MEM_WRITE2(wr[0]), .MEM_SIZE(sz[0]), .MEM_SIGN(sg[0]),
        .MEM_ADDR(ad[0]), .MEM_DIN(di[0]), .MEM_DOUT(dout[0]), .MEM_VALID(valid[0]),
`ifdef OTTER_DMEM_MISALIGN_ERR_EN
        .MEM_ERR(err[0]),
`endif
        .MEM_BUSY(busy[0])
    );

    otter_dmem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .MEM_READ2(rd[1]), .MEM_WRITE2(wr[1]), .MEM_SIZE(sz[1]), .MEM_SIGN(sg[1]),
        .MEM_ADDR(ad[1]), .MEM_DIN(di[1]), .MEM_DOUT(dout[1]), .MEM_VALID(valid[1]),
`ifdef OTTER_DMEM_MISALIGN_ERR_EN
        .MEM_ERR(err[1]),
`endif
        .MEM_BUSY(busy[1])
    );

    int          depth [2] = '{1024, 16};
    int          ws    [2] = '{1, 0};
    logic [31:0] mm    [2][1024];
    logic [31:0] exp_dout [2];
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: byte-granular view of each word, aligned by discarding the
    // address remainder modulo the access size.
    function automatic void model(input int d, input bit w, input bit [1:0] s, input bit g,
                                  input bit [31:0] a, input bit [31:0] x,
                                  output logic [31:0] ed, output bit ee);
        int nb;
        int idx;
        int off;
        int base;
        bit mis;
        logic [31:0] word;
        logic [31:0] v;
        nb   = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        idx  = int'(a >> 2) % depth[d];
        off  = int'(a % 4);
        base = off - (off % nb);
        mis  = (off % nb) != 0;
        word = mm[d][idx];
        v    = 32'd0;
        ee   = 1'b0;
        ed   = exp_dout[d];
`ifdef OTTER_DMEM_MISALIGN_ERR_EN
        if (mis) begin
            ee = 1'b1;
            if (!w) ed = 32'd0;
            exp_dout[d] = ed;
            return;
        end
`else
        if (mis) ee = 1'b0;
`endif
        if (w) begin
            for (int i = 0; i < nb; i++) word[8*(base+i) +: 8] = x[8*i +: 8];
            mm[d][idx] = word;
        end else begin
            for (int i = 0; i < nb; i++) v[8*i +: 8] = word[8*(base+i) +: 8];
            if (!g && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8*nb));
            ed = v;
        end
        exp_dout[d] = ed;
    endfunction

    task automatic txn(input int d, input bit w, input bit r, input bit [1:0] s, input bit g,
                       input bit [31:0] a, input bit [31:0] x);
        logic [31:0] ed;
        bit          ee;
        bit          seen;
        seen = 1'b0;
        model(d, w, s, g, a, x, ed, ee);
        @(posedge clk); #1;
        wr[d] = w; rd[d] = r; sz[d] = s; sg[d] = g; ad[d] = a; di[d] = x;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (valid[d]) begin
                seen = 1'b1;
                check_eq("latency", 32'(c), 32'(1 + ws[d]));
                check_eq("busy_resp", 32'(busy[d]), 32'd0);
                check_eq("dout", dout[d], ed);
`ifdef OTTER_DMEM_MISALIGN_ERR_EN
                check_eq("err", 32'(err[d]), 32'(ee));
`endif
            end else begin
                check_eq("busy_stall", 32'(busy[d]), 32'd1);
            end
        end
        check_eq("valid_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        wr[d] = 1'b0; rd[d] = 1'b0;
        @(negedge clk);
        check_eq("idle_valid", 32'(valid[d]), 32'd0);
        check_eq("idle_busy", 32'(busy[d]), 32'd0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; sg[d] = 1'b0; sz[d] = 2'd0;
            ad[d] = 32'd0; di[d] = 32'd0; exp_dout[d] = 32'd0;
            for (int i = 0; i < 1024; i++) mm[d][i] = 32'd0;
        end
        rst_n = 1'b0;
        rd[1] = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_dout", dout[d], 32'd0);
            check_eq("rst_valid", 32'(valid[d]), 32'd0);
            check_eq("rst_busy", 32'(busy[d]), 32'd0);
`ifdef OTTER_DMEM_MISALIGN_ERR_EN
            check_eq("rst_err", 32'(err[d]), 32'd0);
`endif
        end
        rd[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Known contents for every word the rest of the run touches.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) txn(d, 1'b1, 1'b0, 2'd2, 1'b0, 32'(i * 4), 32'd0);

        // One wait state
        txn(0, 1, 0, 2'd2, 0, 32'h10, 32'hDEADBEEF);
        txn(0, 0, 1, 2'd2, 0, 32'h10, 32'h0);
        txn(0, 1, 0, 2'd2, 0, 32'h20, 32'h0);
        txn(0, 1, 0, 2'd0, 0, 32'h21, 32'h80);
        txn(0, 0, 1, 2'd0, 0, 32'h21, 32'h0);
        txn(0, 0, 1, 2'd0, 1, 32'h21, 32'h0);
        txn(0, 0, 1, 2'd2, 0, 32'h20, 32'h0);
        txn(0, 1, 0, 2'd1, 0, 32'h32, 32'h1234);
        txn(0, 0, 1, 2'd2, 0, 32'h30, 32'h0);
        txn(0, 0, 1, 2'd1, 1, 32'h32, 32'h0);
        txn(0, 0, 1, 2'd2, 0, 32'h13, 32'h0);
        txn(0, 1, 0, 2'd2, 0, 32'h11, 32'h55555555);
        txn(0, 0, 1, 2'd2, 0, 32'h10, 32'h0);
        txn(0, 0, 1, 2'd2, 0, 32'h1010, 32'h0);

        // Zero wait states, including simultaneous read+write
        txn(1, 1, 0, 2'd2, 0, 32'h8, 32'hA5A5_0F0F);
        txn(1, 0, 1, 2'd2, 0, 32'h8, 32'h0);
        txn(1, 1, 1, 2'd2, 0, 32'h8, 32'h1357_9BDF);
        txn(1, 0, 1, 2'd1, 0, 32'h48, 32'h0);

        // Reset during WAIT drops the store
        @(posedge clk); #1;
        wr[0] = 1'b1; sz[0] = 2'd2; ad[0] = 32'h10; di[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_dout", dout[0], 32'd0);
        check_eq("midrst_valid", 32'(valid[0]), 32'd0);
        check_eq("midrst_busy", 32'(busy[0]), 32'd0);
        check_eq("midrst_dout_b", dout[1], 32'd0);
        exp_dout[0] = 32'd0;
        exp_dout[1] = 32'd0;
        @(posedge clk); #1;
        wr[0] = 1'b0;
        rst_n = 1'b1;
        txn(0, 0, 1, 2'd2, 0, 32'h10, 32'h0);

        repeat (200) begin
            int d;
            int op;
            d  = int'($urandom % 2);
            op = int'($urandom_range(1, 3));
            txn(d, op != 1, op != 2, 2'($urandom % 4), 1'($urandom % 2),
                32'(($urandom % 8) * 4 * depth[d]) + ($urandom % 64), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
